// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states and
// the default operand width.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign/magnitude conversion: absolute value of the operands on entry, and conditional
// two's-complement negation of the product or of the quotient/remainder halves on exit.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  input  logic               is_div,
  input  logic               neg_lo,
  input  logic               neg_hi,
  input  logic [2*WIDTH-1:0] raw_res,
  output logic [2*WIDTH-1:0] fix_res
);

  logic [WIDTH-1:0] raw_hi;
  logic [WIDTH-1:0] raw_lo;

  always_comb begin
    abs_a  = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    abs_b  = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    raw_hi = raw_res[2*WIDTH-1:WIDTH];
    raw_lo = raw_res[WIDTH-1:0];
    if (is_div) begin
      // Quotient and remainder carry independent signs.
      fix_res = {(neg_hi ? (~raw_hi + 1'b1) : raw_hi), (neg_lo ? (~raw_lo + 1'b1) : raw_lo)};
    end else begin
      fix_res = neg_lo ? (~raw_res + 1'b1) : raw_res;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Defining MULDIV_FAST_MUL_EN replaces the
// iterative multiply with a single-cycle combinational product (IDLE -> FIX).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  muldiv_state_e      state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] fix_res, mul_next, div_next;
  logic [WIDTH:0]     mul_sum, rem_sh, trial;

  assign signed_op = ~op[0];

  muldiv_signfix #(
    .WIDTH(WIDTH)
  ) u_signfix (
    .signed_op(signed_op),
    .op_a     (srcA),
    .op_b     (srcB),
    .abs_a    (abs_a),
    .abs_b    (abs_b),
    .is_div   (is_div_q),
    .neg_lo   (neg_lo_q),
    .neg_hi   (neg_hi_q),
    .raw_res  (acc_q),
    .fix_res  (fix_res)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = (2*WIDTH)'(abs_a) * (2*WIDTH)'(abs_b);
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    trial    = rem_sh - {1'b0, addend_q};
    if (trial[WIDTH]) begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    addend_d = addend_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hiWrite) hi_d = writeData;
        if (loWrite) lo_d = writeData;
        if (start) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          a_raw_d  = srcA;
          neg_lo_d = signed_op & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
          neg_hi_d = signed_op & srcA[WIDTH-1];
          if (op[1]) begin
            addend_d = abs_b;
            acc_d    = {{WIDTH{1'b0}}, abs_a};
          end else begin
            addend_d = abs_a;
            acc_d    = {{WIDTH{1'b0}}, abs_b};
`ifdef MULDIV_FAST_MUL_EN
            acc_d    = fast_prod;
            state_d  = FIX;
`endif
          end
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q && (addend_q == '0)) begin
          hi_d = a_raw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          {hi_d, lo_d} = fix_res;
          if (is_div_q) dz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      addend_q <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      addend_q <= addend_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divZero = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
